// File: rtl/bnn_ctrl_pkg.sv
// bnn_ctrl_pkg
//   Shared constants for the BNN control blocks. The FSM state encodings are
//   kept as fixed-width constants so that legacy logic decoding the state
//   bits stays compatible. The window geometry constants are also used by
//   the preload shift register and the conv ALU.
//   No ports (package).
package bnn_ctrl_pkg;

    // weight_load_ctrl FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_VALID = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Kernel window geometry: WIN_COLS columns of 5 bits fill WIN_BITS.
    localparam int unsigned WIN_COLS = 5;
    localparam int unsigned WIN_BITS = 25;

endpackage : bnn_ctrl_pkg

// File: rtl/weight_load_ctrl_if.sv
// weight_load_ctrl_if
//   Bundles the sequencer, weight BRAM, preload and ALU handshake signals of
//   weight_load_ctrl.
//   Parameters: ADDR_W (BRAM address width), KCNT_W (n_kernels width).
//   Signals:
//     start, base_addr, n_kernels   sequencer run request
//     bram_en, bram_addr            weight BRAM read port
//     load_weight_preload           preload shift strobe
//     weight_valid, weight_ready    window handshake with the ALU
//     busy, done, stall_cnt         status back to the sequencer
//   Modports: master = the controller, slave = its environment.
interface weight_load_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned KCNT_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [KCNT_W-1:0] n_kernels;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic              load_weight_preload;
    logic              weight_valid;
    logic              weight_ready;
    logic              busy;
    logic              done;
    logic [15:0]       stall_cnt;

    modport master (
        input  start, base_addr, n_kernels, weight_ready,
        output bram_en, bram_addr, load_weight_preload, weight_valid,
               busy, done, stall_cnt
    );

    modport slave (
        output start, base_addr, n_kernels, weight_ready,
        input  bram_en, bram_addr, load_weight_preload, weight_valid,
               busy, done, stall_cnt
    );

endinterface : weight_load_ctrl_if

// File: rtl/wlc_lat_pipe.sv
// wlc_lat_pipe
//   1-bit delay line of DEPTH stages with asynchronous active-low reset.
//   Ports:
//     clk, rst_n     clock, async reset (active-low)
//     i_in           bit entering the line
//     o_out          i_in delayed by exactly DEPTH cycles
//     o_pipe_empty   no set bit behind the output stage, i.e. once the
//                    current output has been presented nothing else is
//                    queued (always 1 for DEPTH=1)
module wlc_lat_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_out,
    output logic o_pipe_empty
);

    logic [DEPTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_d1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= i_in;
            end
            assign o_pipe_empty = 1'b1;
        end else begin : g_dn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= {r_pipe[DEPTH-2:0], i_in};
            end
            // Output stage excluded: the strobe on o_out this cycle is the
            // last one when nothing younger is still travelling.
            assign o_pipe_empty = ~|r_pipe[DEPTH-2:0];
        end
    endgenerate

    assign o_out = r_pipe[DEPTH-1];

endmodule : wlc_lat_pipe

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl
//   Sequences weight fetch for the BNN conv ALU. Per kernel window it issues
//   COLS consecutive BRAM column reads, strobes the preload shift register
//   once per returned column (bram_en delayed BRAM_LAT cycles), then presents
//   weight_valid until the ALU accepts. n_kernels windows are read from
//   consecutive addresses starting at base_addr (wrapping mod 2^ADDR_W).
//   Ports:
//     clk     clock
//     rst_n   asynchronous reset, active-low (aborts a run, drops strobes)
//     bus     weight_load_ctrl_if.master: start/base_addr/n_kernels in,
//             bram_en/bram_addr, load_weight_preload, weight_valid/ready,
//             busy, done, stall_cnt
//   Build option: define WLC_STALL_CNT_EN to count ALU backpressure cycles
//   (valid && !ready, saturating 16 bits, cleared on an accepted start).
//   Without it stall_cnt is tied to zero.
module weight_load_ctrl
    import bnn_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned COLS     = WIN_COLS,
    parameter int unsigned BRAM_LAT = 1,
    parameter int unsigned KCNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    weight_load_ctrl_if.master bus
);

    localparam int unsigned    COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [COL_W-1:0]  r_col;
    logic [KCNT_W-1:0] r_kcnt;

    logic w_fetch;
    logic w_accept;
    logic w_load;
    logic w_pipe_empty;

    assign w_fetch  = (r_state == ST_FETCH);
    assign w_accept = (r_state == ST_IDLE) && bus.start && (bus.n_kernels != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_col   <= '0;
            r_kcnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_FETCH;
                        r_addr  <= bus.base_addr;
                        r_kcnt  <= bus.n_kernels;
                        r_col   <= '0;
                    end
                end
                ST_FETCH: begin
                    // r_addr keeps running across windows so the next kernel
                    // continues at base + k*COLS.
                    r_addr <= r_addr + ADDR_W'(1);
                    if (r_col == LAST_COL) begin
                        r_col   <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_empty) r_state <= ST_VALID;
                end
                ST_VALID: begin
                    if (bus.weight_ready) begin
                        r_kcnt  <= r_kcnt - KCNT_W'(1);
                        r_state <= (r_kcnt == KCNT_W'(1)) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    wlc_lat_pipe #(
        .DEPTH (BRAM_LAT)
    ) u_lat_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in         (w_fetch),
        .o_out        (w_load),
        .o_pipe_empty (w_pipe_empty)
    );

    assign bus.bram_en             = w_fetch;
    assign bus.bram_addr           = r_addr;
    assign bus.load_weight_preload = w_load;
    assign bus.weight_valid        = (r_state == ST_VALID);
    assign bus.busy                = (r_state != ST_IDLE);
    assign bus.done                = (r_state == ST_DONE);

`ifdef WLC_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_VALID) && !bus.weight_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule : weight_load_ctrl

// File: tb/tb_weight_load_ctrl.sv
module tb_weight_load_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned KCNT_W = 8;
    localparam int          COLS   = 5;
    localparam int          NEVER  = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic              start_r;
    logic [ADDR_W-1:0] base_r;
    logic [KCNT_W-1:0] n_r;
    logic              rdy [2];

    weight_load_ctrl_if #(.ADDR_W(ADDR_W), .KCNT_W(KCNT_W)) if_a ();
    weight_load_ctrl_if #(.ADDR_W(ADDR_W), .KCNT_W(KCNT_W)) if_b ();

    assign if_a.start        = start_r;
    assign if_a.base_addr    = base_r;
    assign if_a.n_kernels    = n_r;
    assign if_a.weight_ready = rdy[0];
    assign if_b.start        = start_r;
    assign if_b.base_addr    = base_r;
    assign if_b.n_kernels    = n_r;
    assign if_b.weight_ready = rdy[1];

    weight_load_ctrl #(.ADDR_W(ADDR_W), .COLS(COLS), .BRAM_LAT(1), .KCNT_W(KCNT_W)) u_dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    weight_load_ctrl #(.ADDR_W(ADDR_W), .COLS(COLS), .BRAM_LAT(3), .KCNT_W(KCNT_W)) u_dut_l3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Scoreboard: stimulus pushes expected runs and read addresses here.
    int q_first [2][$];
    int q_n     [2][$];
    int q_addr  [2][$];
    int q_en    [2][$];

    // Reference model state per DUT
    bit active [2];
    int n_k [2], k_done [2], reads [2], strobes [2];
    int valid_from [2], done_at [2];
    int exp_stall [2], held_stall [2], stall_left [2];
    bit seen_valid [2];
    int mode = 0;   // 0: ready tied 1, 1: random ready, 2: 10-cycle stall on first valid

    logic              s_en [2], s_ld [2], s_val [2], s_busy [2], s_done [2];
    logic [ADDR_W-1:0] s_addr [2];
    logic [15:0]       s_stall [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rdy[d] = 1'b1;
            active[d] = 1'b0;
            held_stall[d] = 0;
        end
        forever begin
            @(negedge clk);
            s_en[0] = if_a.bram_en;  s_ld[0] = if_a.load_weight_preload; s_val[0] = if_a.weight_valid;
            s_busy[0] = if_a.busy;   s_done[0] = if_a.done; s_addr[0] = if_a.bram_addr; s_stall[0] = if_a.stall_cnt;
            s_en[1] = if_b.bram_en;  s_ld[1] = if_b.load_weight_preload; s_val[1] = if_b.weight_valid;
            s_busy[1] = if_b.busy;   s_done[1] = if_b.done; s_addr[1] = if_b.bram_addr; s_stall[1] = if_b.stall_cnt;
            for (int d = 0; d < 2; d++) begin
                bit exp_en, exp_ld, exp_val, exp_done, r;
                if (!rst_n) begin
                    chk("reset_outs", d, 32'({s_en[d], s_ld[d], s_val[d], s_busy[d], s_done[d], s_addr[d], s_stall[d]}), 32'd0);
                    active[d] = 1'b0;
                    held_stall[d] = 0;
                    q_first[d].delete(); q_n[d].delete(); q_addr[d].delete(); q_en[d].delete();
                    rdy[d] = 1'b1;
                    continue;
                end
                if (!active[d] && q_first[d].size() > 0 && q_first[d][0] == cyc) begin
                    void'(q_first[d].pop_front());
                    n_k[d] = q_n[d].pop_front();
                    active[d] = 1'b1;
                    k_done[d] = 0; reads[d] = 0; strobes[d] = 0;
                    valid_from[d] = NEVER; done_at[d] = NEVER;
                    exp_stall[d] = 0; stall_left[d] = 0; seen_valid[d] = 1'b0;
                end
                if (!active[d])
                    chk("stall_cnt_idle", d, 32'(s_stall[d]), 32'(held_stall[d]));

                // BRAM reads: COLS consecutive cycles at the start of each window
                exp_en = active[d] && (reads[d] < COLS) && (k_done[d] < n_k[d]);
                chk("bram_en", d, 32'(s_en[d]), 32'(exp_en));
                if (exp_en && s_en[d]) begin
                    chk("bram_addr", d, 32'(s_addr[d]), (q_addr[d].size() > 0) ? 32'(q_addr[d].pop_front()) : 32'hffff_ffff);
                    q_en[d].push_back(cyc);
                    reads[d]++;
                end

                // Preload strobes: each read returns exactly BRAM_LAT cycles later
                exp_ld = (q_en[d].size() > 0) && (q_en[d][0] + lat_of(d) == cyc);
                chk("strobe", d, 32'(s_ld[d]), 32'(exp_ld));
                if (exp_ld) begin
                    void'(q_en[d].pop_front());
                    strobes[d]++;
                    if (strobes[d] == COLS) valid_from[d] = cyc + 1;
                end

                exp_val = active[d] && (strobes[d] == COLS) && (cyc >= valid_from[d]);
                case (mode)
                    1: r = ($urandom_range(0, 3) != 0);
                    2: begin
                        if (exp_val && !seen_valid[d]) begin
                            seen_valid[d] = 1'b1;
                            stall_left[d] = 10;
                        end
                        r = (stall_left[d] == 0);
                        if (stall_left[d] > 0) stall_left[d]--;
                    end
                    default: r = 1'b1;
                endcase
                rdy[d] = r;

                chk("weight_valid", d, 32'(s_val[d]), 32'(exp_val));
                if (exp_val) begin
                    if (!r) begin
                        exp_stall[d]++;
                    end else begin
                        k_done[d]++;
                        strobes[d] = 0;
                        valid_from[d] = NEVER;
                        if (k_done[d] == n_k[d]) done_at[d] = cyc + 1;
                        else                     reads[d] = 0;
                    end
                end

                exp_done = active[d] && (cyc == done_at[d]);
                chk("done", d, 32'(s_done[d]), 32'(exp_done));
                chk("busy", d, 32'(s_busy[d]), 32'(active[d]));
                if (exp_done) begin
`ifdef WLC_STALL_CNT_EN
                    chk("stall_cnt", d, 32'(s_stall[d]), 32'(exp_stall[d]));
                    if (mode == 2) chk("stall_cnt_10", d, 32'(s_stall[d]), 32'd10);
                    held_stall[d] = exp_stall[d];
`else
                    chk("stall_cnt", d, 32'(s_stall[d]), 32'd0);
                    held_stall[d] = 0;
`endif
                    active[d] = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((active[0] || active[1] || q_n[0].size() > 0 || q_n[1].size() > 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
        end
        @(negedge clk);
    endtask

    // restart: extra start pulse in FETCH cycle 2 (must be ignored)
    // mid_reset: reset asserted during FETCH cycle 3
    task automatic run(input int base_i, input int n_i, input int mode_i, input bit restart, input bit mid_reset);
        wait_idle();
        mode    = mode_i;
        base_r  = ADDR_W'(base_i);
        n_r     = KCNT_W'(n_i);
        start_r = 1'b1;
        if (n_i != 0) begin
            for (int d = 0; d < 2; d++) begin
                q_first[d].push_back(cyc + 1);
                q_n[d].push_back(n_i);
                for (int i = 0; i < n_i * COLS; i++)
                    q_addr[d].push_back((base_i + i) % (1 << ADDR_W));
            end
        end
        @(negedge clk);
        start_r = 1'b0;
        if (restart) begin
            @(negedge clk);
            start_r = 1'b1;
            base_r  = 10'h2a0;
            n_r     = 8'd3;
            @(negedge clk);
            start_r = 1'b0;
        end
        if (mid_reset) begin
            @(negedge clk);
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("async_reset", 0, 32'({if_a.bram_en, if_a.load_weight_preload, if_a.weight_valid,
                                       if_a.busy, if_a.done, if_a.bram_addr, if_a.stall_cnt}), 32'd0);
            chk("async_reset", 1, 32'({if_b.bram_en, if_b.load_weight_preload, if_b.weight_valid,
                                       if_b.busy, if_b.done, if_b.bram_addr, if_b.stall_cnt}), 32'd0);
            @(negedge clk);
            #2 rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_r = 1'b0;
        base_r  = '0;
        n_r     = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        run(10'h010, 1, 0, 1'b0, 1'b0);   // single kernel, ready tied high
        run(10'h010, 2, 2, 1'b0, 1'b0);   // backpressure, second window at 0x015
        run(10'h3fe, 1, 0, 1'b0, 1'b0);   // address wrap
        run(10'h055, 0, 0, 1'b0, 1'b0);   // n=0: start ignored
        run(10'h100, 2, 1, 1'b1, 1'b0);   // start pulse during FETCH ignored
        run(10'h080, 3, 1, 1'b0, 1'b1);   // reset mid-run
        run(10'h0c0, 1, 0, 1'b0, 1'b0);   // clean window after reset
        for (int i = 0; i < 12; i++)
            run(int'($urandom_range(0, 1023)), int'($urandom_range(0, 4)), 1, 1'b0, 1'b0);
        run(10'h3fc, 2, 2, 1'b0, 1'b0);   // stall across the wrap point
        wait_idle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_weight_load_ctrl
